instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Initiator side of the instruction-memory read port: owns the program counter and drives `ReadAddress`.
- Captures the combinational `Instruction` return into a small prefetch FIFO.
- Presents fetched words with their PC to decode over a valid/ready handshake.
- Sits between the instruction memory and the decode stage; also takes branch redirects from execute.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0: PC loaded on reset.
- `ADDR_LIMIT`, 32'd64: highest legal fetch address; used only when bounds check is compiled in.
- `Clk`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `ReadAddress`  out  32  fetch address to instruction memory; equals PC register.
- `Instruction`  in  32  memory data for `ReadAddress`, valid the same cycle (combinational memory).
- `BranchTaken`  in  1  redirect request from execute.
- `BranchTarget`  in  32  redirect address; bits [1:0] forced to 0 on load.
- `InstrValid`  out  1  FIFO head holds a valid entry.
- `InstrReady`  in  1  decode accepts head this cycle.
- `InstrOut`  out  32  instruction word at FIFO head.
- `InstrPC`  out  32  fetch address of `InstrOut`.
- `AddrFault`  out  1  sticky bounds-violation flag.

## Operation
- Memory is indexed by byte address; sequential fetch steps PC by 4.
- State: `PC`, FIFO storage of `DEPTH` × {pc[31:0], instr[31:0]}, `wr_ptr`/`rd_ptr` (log2(DEPTH) bits, wrapping), `count` (log2(DEPTH)+1 bits), `fault`.
- pop = `InstrValid && InstrReady`.
- push = `!BranchTaken && !fault && (count < DEPTH || pop)`.
- On push: write {PC, `Instruction`} at `wr_ptr`, increment `wr_ptr`, set PC ← PC + 4 (32-bit wrap, no carry out).
- On pop: increment `rd_ptr`.
- Count update: `count` += push − pop. Push and pop together on a full FIFO is legal; count stays at `DEPTH`.
- Redirect has priority over push and pop. If `BranchTaken`=1:
  - `count`←0, `rd_ptr`←`wr_ptr`←0.
  - PC←{`BranchTarget`[31:2],2'b00}.
  - Any concurrent pop is discarded: decode must treat a head presented in the redirect cycle as squashed.
- `InstrValid` = (`count` != 0). `InstrOut`/`InstrPC` read the FIFO at `rd_ptr`. When empty they show the last head and must be ignored.
- Reset:
  - PC=`RESET_PC`, so `ReadAddress`=`RESET_PC`.
  - `count`=0, pointers=0, `InstrValid`=0.
  - `InstrOut`=0, `InstrPC`=0 (storage cleared), `AddrFault`=0.
- Reset mid-operation discards all entries and any pending redirect.

## Timing
- Fetch latency: PC presented in cycle n is captured at the end of n and appears at the head in n+1 if the FIFO was empty.
- Throughput: one instruction per cycle sustained while `InstrReady`=1.
- Redirect asserted in cycle n:
  - `InstrValid`=0 in n+1.
  - `ReadAddress`=target in n+1.
  - Target instruction is valid at the head in n+2.
- Back-pressure: with `InstrReady`=0, the FIFO fills in `DEPTH` cycles, then PC holds.
- `ReadAddress` is a register output and never glitches on input changes.

## Configuration
- `IFU_BOUNDS_CHECK_EN` defined:
  - A push whose PC > `ADDR_LIMIT` does not occur.
  - `fault` sets the same edge and is sticky until `Reset`.
  - `AddrFault`=1 from the next cycle.
  - All further pushes are blocked; the FIFO drains normally.
  - A `BranchTaken` does not clear `fault`.
- Not defined:
  - No check; `AddrFault` is tied to 0 and `fault` is not implemented.
  - Fetch continues past `ADDR_LIMIT`; the memory returns whatever its array yields.

## Test plan
- Reset release, memory with 0x02324020@0, 0x02744820@4, 0x01098022@8, `InstrReady`=1:
  - Cycle 1: head {0,0x02324020}.
  - Cycle 2: {4,0x02744820}.
  - Cycle 3: {8,0x01098022}.
  - `ReadAddress` = 0,4,8,12 in cycles 0..3.
- `InstrReady`=0 from reset:
  - After 4 cycles `count`=4; PC holds at 16.
  - Raise `InstrReady`: heads 0,4,8,12 in order, then 16 with no gap.
- Full FIFO with pop and push in the same cycle: count stays 4 and PC advances by 4 exactly once.
- `BranchTaken`=1, `BranchTarget`=32'h43 while 3 entries are queued:
  - Next cycle: `InstrValid`=0, `ReadAddress`=0x40.
  - Cycle after: head {0x40, mem[0x40]}.
- Reset asserted while the FIFO holds 2 entries and a redirect is pending: next cycle all outputs are at reset values and `ReadAddress`=`RESET_PC`.
- With `IFU_BOUNDS_CHECK_EN`, `ADDR_LIMIT`=8, decode always ready:
  - Entries 0,4,8 are delivered.
  - `AddrFault`=1 in the cycle after PC reaches 12.
  - No entry with PC 12 ever appears.
  - A branch to 0 does not resume fetch.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose: initiator side of a combinational instruction-memory read port.
// Owns the program counter, captures each fetched word together with its PC
// into a small prefetch FIFO, and presents the FIFO head to decode over a
// valid/ready handshake. Branch redirects from execute flush the FIFO and
// reload the PC.
//
// Optional feature: define IFU_BOUNDS_CHECK_EN to compile in a fetch-address
// bounds check against ADDR_LIMIT (sticky AddrFault, further pushes blocked).
// Without it AddrFault is tied to 0 and fetch runs unchecked.
//
// Parameters:
//   DEPTH      prefetch FIFO entries (power of two, >= 2)
//   RESET_PC   PC loaded on reset
//   ADDR_LIMIT highest legal fetch address (bounds-check build only)
//
// Ports:
//   Clk           in   clock, all state updates on the rising edge
//   Reset         in   synchronous, active-high
//   ReadAddress   out  [31:0] fetch address (PC register)
//   Instruction   in   [31:0] memory data for ReadAddress, same cycle
//   BranchTaken   in   redirect request from execute
//   BranchTarget  in   [31:0] redirect address, low two bits ignored
//   InstrValid    out  FIFO head holds a valid entry
//   InstrReady    in   decode accepts the head this cycle
//   InstrOut      out  [31:0] instruction word at FIFO head
//   InstrPC       out  [31:0] fetch address of InstrOut
//   AddrFault     out  sticky bounds-violation flag
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] ADDR_LIMIT = 32'd64
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] ReadAddress,
    input  logic [31:0] Instruction,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC,
    output logic        AddrFault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_pc_q  [DEPTH];
    logic [31:0]   fifo_pc_d  [DEPTH];
    logic [31:0]   fifo_ins_q [DEPTH];
    logic [31:0]   fifo_ins_d [DEPTH];

    logic pop;
    logic room;
    logic push;
    logic fault;
    logic in_bounds;

    // Target word alignment discards the low two bits.
    logic unused_target_bits;
    assign unused_target_bits = ^BranchTarget[1:0];

`ifdef IFU_BOUNDS_CHECK_EN
    logic fault_q, fault_d;

    assign in_bounds = (pc_q <= ADDR_LIMIT);
    assign fault     = fault_q;

    // The fault latches on exactly the edge where an out-of-range push would
    // have happened; a redirect in that cycle suppresses the attempt.
    always_comb begin
        fault_d = fault_q;
        if (!BranchTaken && !fault_q && room && !in_bounds) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^ADDR_LIMIT;
    assign in_bounds    = 1'b1;
    assign fault        = 1'b0;
`endif

    assign ReadAddress = pc_q;
    assign InstrValid  = (count_q != '0);
    assign InstrOut    = fifo_ins_q[rd_ptr_q];
    assign InstrPC     = fifo_pc_q[rd_ptr_q];
    assign AddrFault   = fault;

    assign pop  = InstrValid && InstrReady;
    // count never exceeds DEPTH, so "not full" is the same as count < DEPTH;
    // a simultaneous pop frees the slot being written.
    assign room = (count_q != FULL_CNT) || pop;
    assign push = !BranchTaken && !fault && room && in_bounds;

    always_comb begin
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_pc_d  = fifo_pc_q;
        fifo_ins_d = fifo_ins_q;

        if (BranchTaken) begin
            // Redirect wins over push and pop; a head handed over this cycle
            // is squashed along with the rest of the FIFO.
            pc_d     = {BranchTarget[31:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]  = pc_q;
                fifo_ins_d[wr_ptr_q] = Instruction;
                wr_ptr_d             = wr_ptr_q + PTR_ONE;
                pc_d                 = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]  <= '0;
                fifo_ins_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_ins_q <= fifo_ins_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Bench for instruction_fetch_unit. A cycle-accurate vector table covers the
// reset, streaming, back-pressure, full-FIFO, redirect and reset-during-
// redirect sequences; a scoreboard then follows a randomized ready/redirect
// run. When IFU_BOUNDS_CHECK_EN is defined the DUT is built with
// ADDR_LIMIT = 8 and the bounds-check sequence replaces the sequences that
// fetch past that limit.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

`ifdef IFU_BOUNDS_CHECK_EN
    localparam logic [31:0] LIM = 32'd8;
`else
    localparam logic [31:0] LIM = 32'd64;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] ReadAddress;
    logic [31:0] Instruction;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [31:0] InstrOut;
    logic [31:0] InstrPC;
    logic        AddrFault;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    instruction_fetch_unit #(
        .DEPTH     (4),
        .RESET_PC  (32'h0),
        .ADDR_LIMIT(LIM)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ReadAddress (ReadAddress),
        .Instruction (Instruction),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .InstrOut    (InstrOut),
        .InstrPC     (InstrPC),
        .AddrFault   (AddrFault)
    );

    // Combinational instruction memory.
    function automatic logic [31:0] m(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0232_4020;
            32'h4:   return 32'h0274_4820;
            32'h8:   return 32'h0109_8022;
            default: return 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    always_comb Instruction = m(ReadAddress);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        chk_en;
        logic [31:0] ra;
        logic        v;
        logic        hc;
        logic [31:0] hpc;
        logic [31:0] hins;
        logic        flt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic rdy, input logic br, input logic [31:0] tgt,
                       input logic chk_en, input logic [31:0] ra, input logic v, input logic hc,
                       input logic [31:0] hpc, input logic [31:0] hins, input logic flt);
        vec_t e;
        e.rst = rst; e.rdy = rdy; e.br = br; e.tgt = tgt; e.chk_en = chk_en;
        e.ra = ra; e.v = v; e.hc = hc; e.hpc = hpc; e.hins = hins; e.flt = flt;
        tbl.push_back(e);
    endtask

    // Ordinary row: no reset, head checked whenever it is valid.
    task automatic r(input logic rdy, input logic br, input logic [31:0] tgt,
                     input logic [31:0] ra, input logic v, input logic [31:0] hpc);
        add(1'b0, rdy, br, tgt, 1'b1, ra, v, v, hpc, m(hpc), 1'b0);
    endtask

    // Reset row: outputs in this cycle still reflect the old state.
    task automatic rs();
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // First cycle after reset: empty, storage cleared, PC at RESET_PC.
    task automatic after_rst(input logic rdy);
        add(1'b0, rdy, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t sb[$];

    task automatic refill(input logic [31:0] start);
        ent_t e;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            e.pc  = start + 32'(4 * i);
            e.ins = m(e.pc);
            sb.push_back(e);
        end
    endtask

    initial begin
        // Streaming from reset with decode always ready.
        rs();
        after_rst(1'b1);
        r(1, 0, 0, 32'd4, 1, 32'd0);
        r(1, 0, 0, 32'd8, 1, 32'd4);
        r(1, 0, 0, 32'd12, 1, 32'd8);

        // Reset while two entries are queued and a redirect is requested.
        rs();
        after_rst(1'b0);
        r(0, 0, 0, 32'd4, 1, 32'd0);
        add(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'd8, 1'b1, 1'b1, 32'd0, m(32'd0), 1'b0);
        after_rst(1'b0);
        r(0, 0, 0, 32'd4, 1, 32'd0);

`ifndef IFU_BOUNDS_CHECK_EN
        // Back-pressure: fill, hold PC, full push+pop, then drain without gaps.
        rs();
        after_rst(1'b0);
        r(0, 0, 0, 32'd4, 1, 32'd0);
        r(0, 0, 0, 32'd8, 1, 32'd0);
        r(0, 0, 0, 32'd12, 1, 32'd0);
        r(0, 0, 0, 32'd16, 1, 32'd0);
        r(0, 0, 0, 32'd16, 1, 32'd0);
        r(1, 0, 0, 32'd16, 1, 32'd0);
        r(0, 0, 0, 32'd20, 1, 32'd4);
        r(0, 0, 0, 32'd20, 1, 32'd4);
        r(1, 0, 0, 32'd20, 1, 32'd4);
        r(1, 0, 0, 32'd24, 1, 32'd8);
        r(1, 0, 0, 32'd28, 1, 32'd12);
        r(1, 0, 0, 32'd32, 1, 32'd16);
        r(1, 0, 0, 32'd36, 1, 32'd20);

        // Redirect to an unaligned target with three entries queued; fetch
        // continues past ADDR_LIMIT because no bounds check is built in.
        rs();
        after_rst(1'b0);
        r(0, 0, 0, 32'd4, 1, 32'd0);
        r(0, 0, 0, 32'd8, 1, 32'd0);
        r(1, 1, 32'h43, 32'd12, 1, 32'd0);
        r(1, 0, 0, 32'h40, 0, 32'd0);
        r(1, 0, 0, 32'h44, 1, 32'h40);
        r(1, 0, 0, 32'h48, 1, 32'h44);
`else
        // Bounds check with ADDR_LIMIT = 8.
        rs();
        after_rst(1'b1);
        r(1, 0, 0, 32'd4, 1, 32'd0);
        r(1, 0, 0, 32'd8, 1, 32'd4);
        r(1, 0, 0, 32'd12, 1, 32'd8);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd12, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'd12, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        rs();
        after_rst(1'b1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge Clk);
            if (tbl[i].chk_en) begin
                chk($sformatf("row%0d ReadAddress", i), ReadAddress, tbl[i].ra);
                chk($sformatf("row%0d InstrValid", i), 32'(InstrValid), 32'(tbl[i].v));
                chk($sformatf("row%0d AddrFault", i), 32'(AddrFault), 32'(tbl[i].flt));
                if (tbl[i].hc) begin
                    chk($sformatf("row%0d InstrPC", i), InstrPC, tbl[i].hpc);
                    chk($sformatf("row%0d InstrOut", i), InstrOut, tbl[i].hins);
                end
            end
            Reset        = tbl[i].rst;
            InstrReady   = tbl[i].rdy;
            BranchTaken  = tbl[i].br;
            BranchTarget = tbl[i].tgt;
        end

`ifndef IFU_BOUNDS_CHECK_EN
        begin
            int          pops = 0;
            int          since = 0;
            logic        pend = 1'b0;
            logic [31:0] exp_tgt = 32'h0;
            logic        rdy;
            logic        br;
            logic [31:0] tgt;
            ent_t        e;

            @(negedge Clk);
            Reset       = 1'b1;
            InstrReady  = 1'b0;
            BranchTaken = 1'b0;
            @(negedge Clk);
            Reset = 1'b0;
            refill(32'h0);
            for (int c = 0; c < 400; c++) begin
                @(negedge Clk);
                if (pend) begin
                    chk("redir InstrValid", 32'(InstrValid), 32'h0);
                    chk("redir ReadAddress", ReadAddress, exp_tgt);
                    pend = 1'b0;
                end
                rdy = ($urandom_range(0, 3) != 0);
                br  = (since >= 40) || ($urandom_range(0, 29) == 0);
                tgt = 32'($urandom_range(0, 1023));
                InstrReady   = rdy;
                BranchTaken  = br;
                BranchTarget = tgt;
                if (InstrValid && rdy && !br) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb underflow actual=pop required=no-pop");
                    end else begin
                        e = sb.pop_front();
                        chk("sb InstrPC", InstrPC, e.pc);
                        chk("sb InstrOut", InstrOut, e.ins);
                        pops++;
                    end
                end
                if (br) begin
                    exp_tgt = {tgt[31:2], 2'b00};
                    refill(exp_tgt);
                    pend  = 1'b1;
                    since = 0;
                end else begin
                    since++;
                end
            end
            @(negedge Clk);
            BranchTaken = 1'b0;
            InstrReady  = 1'b0;
            total++;
            if (pops < 100) begin
                bad++;
                $display("FAIL sb throughput actual=%0d required>=100", pops);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
